// File: rtl/joystick_splitter_scan.sv
// Joystick splitter front end: scans up to four DB9 joysticks through a select-line splitter.
// Each slot is debounced, and F1 can be gated by a per-slot autofire phase taken from a
// frame counter driven by vertical retrace. The autofire config register sits on the ZXUNO bus.
`timescale 1ns/1ps

module joystick_splitter_scan #(
  parameter int unsigned NUM_SLOTS  = 2,
  parameter int unsigned SCAN_DIV   = 140000,
  parameter int unsigned SETTLE     = 64,
  parameter int unsigned DEBOUNCE   = 2,
  parameter logic [7:0]  AFCONFADDR = 8'h0F
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   split_en,
  input  logic [5:0]             db9_in,
  output logic [1:0]             joy_sel,
  input  logic [7:0]             zxuno_addr,
  input  logic                   zxuno_regwr,
  input  logic                   zxuno_regrd,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   oe,
  input  logic                   vretrace_n,
  output logic [6*NUM_SLOTS-1:0] joy_out,
  output logic                   scan_tick
);

  localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntLast   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntSettle = CntW'(SETTLE);
  localparam logic [2:0]      DbMax     = 3'(DEBOUNCE);
  localparam logic [1:0]      SlotLast  = 2'(NUM_SLOTS - 1);
  localparam logic [3:0]      SlotMask  = 4'((1 << NUM_SLOTS) - 1);

  logic [CntW-1:0] cnt;
  logic [5:0]      prev_q [NUM_SLOTS];
  logic [2:0]      db_q   [NUM_SLOTS];
  logic [5:0]      raw_q  [NUM_SLOTS];

  logic [7:0] afconf;
  logic [3:0] fc;
  logic       vr_q;

  logic [5:0] sample;
  logic [5:0] cur_prev;
  logic [2:0] cur_db;
  logic [5:0] cur_raw;
  logic [2:0] db_next;
  logic       commit;
  logic       af;
  logic       afconf_hit;
  logic       unused_din;

  assign sample     = ~db9_in;
  assign afconf_hit = (zxuno_addr == AFCONFADDR);
  assign af         = fc[afconf[5:4]];
  // Reserved config bits are never stored.
  assign unused_din = ^din[7:6];

  // Debounce next-state for the slot currently selected.
  always_comb begin
    cur_prev = '0;
    cur_db   = '0;
    cur_raw  = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if (joy_sel == 2'(k)) begin
        cur_prev = prev_q[k];
        cur_db   = db_q[k];
        cur_raw  = raw_q[k];
      end
    end
    if (sample == cur_prev) begin
      db_next = (cur_db >= DbMax) ? DbMax : cur_db + 3'd1;
    end else begin
      db_next = 3'd1;
    end
    commit = (db_next == DbMax) && (sample != cur_raw);
  end

  // Dwell counter, slot select and per-slot debounce/commit state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      joy_sel   <= '0;
      scan_tick <= 1'b0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
        prev_q[k] <= '0;
        db_q[k]   <= '0;
        raw_q[k]  <= '0;
      end
    end else begin
      scan_tick <= 1'b0;
      cnt       <= (cnt == CntLast) ? '0 : cnt + 1'b1;

      if (!split_en) begin
        joy_sel <= '0;
      end else if (cnt == CntLast) begin
        joy_sel <= (joy_sel == SlotLast) ? 2'd0 : joy_sel + 2'd1;
      end

      if (cnt == CntSettle) begin
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
          if (joy_sel == 2'(k)) begin
            prev_q[k] <= sample;
            db_q[k]   <= db_next;
            if (commit) begin
              raw_q[k] <= sample;
            end
          end
        end
        // A slot about to be cleared by direct mode must not announce a commit.
        scan_tick <= commit && (split_en || joy_sel == 2'd0);
      end

      // Direct mode: slots behind the splitter read as released and restart debouncing.
      if (!split_en) begin
        for (int unsigned k = 1; k < NUM_SLOTS; k++) begin
          prev_q[k] <= '0;
          db_q[k]   <= '0;
          raw_q[k]  <= '0;
        end
      end
    end
  end

  // Autofire config register and retrace-driven frame counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      afconf <= 8'h00;
      fc     <= 4'd0;
      vr_q   <= vretrace_n;
    end else begin
      vr_q <= vretrace_n;
      if (vretrace_n && !vr_q) begin
        fc <= fc + 4'd1;
      end
      if (afconf_hit && zxuno_regwr) begin
        afconf <= {2'b00, din[5:4], din[3:0] & SlotMask};
      end
    end
  end

  // Slot outputs with F1 gated by the autofire phase where enabled.
  always_comb begin
    joy_out = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      joy_out[6*k +: 6] = {raw_q[k][5],
                           raw_q[k][4] & (afconf[k] ? af : 1'b1),
                           raw_q[k][3:0]};
    end
  end

  // Register read port, combinational on the current register value.
  always_comb begin
    oe   = 1'b0;
    dout = 8'hFF;
    if (afconf_hit && zxuno_regrd) begin
      oe   = 1'b1;
      dout = afconf;
    end
  end

endmodule

// File: tb/tb_joystick_splitter_scan.sv
// Directed bench for joystick_splitter_scan: a 3-slot instance for scanning, debounce, direct
// mode and autofire, plus a 2-slot instance for register masking.
`timescale 1ns/1ps

module tb_joystick_splitter_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        split_en;
  logic [5:0]  db9_in;
  logic [7:0]  zxuno_addr;
  logic        zxuno_regwr;
  logic        zxuno_regrd;
  logic [7:0]  din;
  logic        vretrace_n;

  logic [1:0]  joy_sel;
  logic [7:0]  dout;
  logic        oe;
  logic [17:0] joy_out;
  logic        scan_tick;

  logic [1:0]  joy_sel2;
  logic [7:0]  dout2;
  logic        oe2;
  logic [11:0] joy_out2;
  logic        scan_tick2;

  // Raw DB9 level seen behind each splitter port.
  logic [5:0]  pat [4];

  int errors = 0;
  int checks = 0;
  int ticks  = 0;

  always #5 clk = ~clk;

  // Splitter: the DB9 port shows whichever joystick is selected.
  always_comb db9_in = pat[joy_sel];

  joystick_splitter_scan #(
    .NUM_SLOTS (3),
    .SCAN_DIV  (16),
    .SETTLE    (4),
    .DEBOUNCE  (2),
    .AFCONFADDR(8'h0F)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .split_en   (split_en),
    .db9_in     (db9_in),
    .joy_sel    (joy_sel),
    .zxuno_addr (zxuno_addr),
    .zxuno_regwr(zxuno_regwr),
    .zxuno_regrd(zxuno_regrd),
    .din        (din),
    .dout       (dout),
    .oe         (oe),
    .vretrace_n (vretrace_n),
    .joy_out    (joy_out),
    .scan_tick  (scan_tick)
  );

  joystick_splitter_scan #(
    .NUM_SLOTS (2),
    .SCAN_DIV  (16),
    .SETTLE    (4),
    .DEBOUNCE  (2),
    .AFCONFADDR(8'h0F)
  ) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .split_en   (split_en),
    .db9_in     (db9_in),
    .joy_sel    (joy_sel2),
    .zxuno_addr (zxuno_addr),
    .zxuno_regwr(zxuno_regwr),
    .zxuno_regrd(zxuno_regrd),
    .din        (din),
    .dout       (dout2),
    .oe         (oe2),
    .vretrace_n (vretrace_n),
    .joy_out    (joy_out2),
    .scan_tick  (scan_tick2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (scan_tick) ticks++;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic dwell();
    tick_n(16);
  endtask

  initial begin
    rst_n       = 1'b0;
    split_en    = 1'b1;
    zxuno_addr  = 8'h00;
    zxuno_regwr = 1'b0;
    zxuno_regrd = 1'b0;
    din         = 8'h00;
    vretrace_n  = 1'b1;
    for (int i = 0; i < 4; i++) pat[i] = 6'h00;

    // Reset with every DB9 pin asserted.
    tick_n(3);
    check("rst_joy_out", joy_out, 18'h0);
    check("rst_joy_sel", joy_sel, 2'd0);
    check("rst_scan_tick", scan_tick, 1'b0);
    check("rst_oe", oe, 1'b0);
    check("rst_dout", dout, 8'hFF);
    check("rst_joy_out2", joy_out2, 12'h0);
    check("rst_joy_sel2", joy_sel2, 2'd0);
    check("rst_scan_tick2", scan_tick2, 1'b0);
    zxuno_addr  = 8'h0F;
    zxuno_regrd = 1'b1;
    #1;
    check("rst_afconf", dout, 8'h00);
    check("rst_afconf_oe", oe, 1'b1);
    zxuno_regrd = 1'b0;

    // Scan: pressed slot0=21, slot1=0C, slot2=10.
    pat[0] = 6'h1E;
    pat[1] = 6'h33;
    pat[2] = 6'h2F;
    pat[3] = 6'h3F;
    rst_n  = 1'b1;
    ticks  = 0;
    dwell();
    check("sel_seq1", joy_sel, 2'd1);
    check("slot0_one_sample", joy_out[5:0], 6'h00);
    dwell();
    check("sel_seq2", joy_sel, 2'd2);
    dwell();
    check("sel_seq0", joy_sel, 2'd0);
    check("no_tick_first_round", ticks, 0);
    dwell();
    check("slot0_commit", joy_out[5:0], 6'h21);
    check("tick_slot0", ticks, 1);
    dwell();
    check("slot1_commit", joy_out[11:6], 6'h0C);
    check("tick_slot1", ticks, 2);
    dwell();
    check("all_commit", joy_out, 18'h10321);
    check("tick_slot2", ticks, 3);

    // Slot 1 released, then a single-sample glitch.
    pat[1] = 6'h3F;
    ticks  = 0;
    tick_n(6 * 16);
    check("slot1_release", joy_out, 18'h10021);
    check("tick_release", ticks, 1);
    dwell();
    ticks  = 0;
    pat[1] = 6'h3E;
    dwell();
    pat[1] = 6'h3F;
    check("glitch_slot1_now", joy_out[11:6], 6'h00);
    tick_n(6 * 16);
    check("glitch_slot1_later", joy_out[11:6], 6'h00);
    check("glitch_no_tick", ticks, 0);

    // Direct mode entered while slot 2 is selected and holding F1.
    check("pre_direct_sel", joy_sel, 2'd2);
    tick_n(2);
    split_en = 1'b0;
    ticks    = 0;
    tick();
    check("direct_sel0", joy_sel, 2'd0);
    check("direct_slot2_clear", joy_out[17:12], 6'h00);
    check("direct_slot0_kept", joy_out[5:0], 6'h21);
    pat[0] = 6'h3D;
    tick_n(32);
    check("direct_slot0_track", joy_out[5:0], 6'h02);
    check("direct_sel_hold", joy_sel, 2'd0);
    check("direct_slots12_zero", joy_out[17:6], 12'h000);
    check("direct_tick", ticks, 1);
    tick_n(13);

    // Scanning resumes at slot 0; F1 held on every slot.
    pat[0]   = 6'h2F;
    pat[1]   = 6'h2F;
    pat[2]   = 6'h2F;
    split_en = 1'b1;
    ticks    = 0;
    dwell();
    check("resume_sel", joy_sel, 2'd1);
    tick_n(5 * 16);
    check("f1_all", joy_out, 18'h10410);
    check("f1_ticks", ticks, 3);

    // Autofire on slot 0 at R=1: F1 follows bit 1 of the frame count.
    zxuno_addr  = 8'h0F;
    din         = 8'h11;
    zxuno_regwr = 1'b1;
    tick();
    zxuno_regwr = 1'b0;
    zxuno_regrd = 1'b1;
    #1;
    check("afconf_11", dout, 8'h11);
    check("afconf_11_n2", dout2, 8'h11);
    zxuno_regrd = 1'b0;
    for (int f = 0; f <= 8; f++) begin
      check($sformatf("af_slot0_f%0d", f), joy_out[4], 32'((f >> 1) & 1));
      check($sformatf("af_slot1_f%0d", f), joy_out[10], 1'b1);
      if (f < 8) begin
        vretrace_n = 1'b0;
        tick();
        vretrace_n = 1'b1;
        tick();
      end
    end

    // Retrace edge and write of R=0 on the same clock: fc 8->9, phase fc[0]=1.
    vretrace_n  = 1'b0;
    tick();
    vretrace_n  = 1'b1;
    din         = 8'h01;
    zxuno_regwr = 1'b1;
    tick();
    zxuno_regwr = 1'b0;
    check("af_edge_and_write", joy_out[4], 1'b1);

    // Read during write: old value now, masked new value next cycle.
    din         = 8'hA5;
    zxuno_regwr = 1'b1;
    zxuno_regrd = 1'b1;
    #1;
    check("rw_old_value", dout, 8'h01);
    check("rw_old_oe", oe, 1'b1);
    check("rw_old_value_n2", dout2, 8'h01);
    tick();
    zxuno_regwr = 1'b0;
    #1;
    check("rw_new_value", dout, 8'h25);
    check("rw_new_value_n2", dout2, 8'h21);
    check("rw_new_oe_n2", oe2, 1'b1);
    zxuno_addr = 8'h0E;
    #1;
    check("other_addr_oe", oe, 1'b0);
    check("other_addr_dout", dout, 8'hFF);
    zxuno_regrd = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
